// File: rtl/irst_reg_streamer.sv
// irst register-dump transmitter: snapshots the register array, then streams it with a rotate-XOR signature.
// Optional macro IRST_PARITY_EN adds irst_parity and irst_sig_par outputs.
module irst_reg_streamer #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] reg_read_addr,
    input  logic [DATA_W-1:0] reg_read_data,
    output logic [DATA_W-1:0] irst_reg_data,
    output logic [ADDR_W-1:0] irst_idx,
    output logic              irst_valid,
    input  logic              irst_ready,
    output logic              irst_done,
    output logic              busy,
`ifdef IRST_PARITY_EN
    output logic              irst_parity,
    output logic              irst_sig_par,
`endif
    output logic [DATA_W-1:0] irst_sig
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_SEND,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] sig_q, sig_d;
    logic [DATA_W-1:0] snap_q [NUM_REGS];
    logic              cap_en;
    logic              last;
    logic [DATA_W-1:0] cur_word;

    assign last     = (idx_q == ADDR_W'(NUM_REGS - 1));
    assign cur_word = snap_q[idx_q];

`ifdef IRST_PARITY_EN
    logic sig_par_q, sig_par_d;
`endif

    // Next-state logic: capture sweep, handshake-paced send, signature fold
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sig_d   = sig_q;
        cap_en  = 1'b0;
`ifdef IRST_PARITY_EN
        sig_par_d = sig_par_q;
`endif
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_CAPTURE;
                    idx_d   = '0;
                    sig_d   = '0;
`ifdef IRST_PARITY_EN
                    sig_par_d = 1'b0;
`endif
                end
            end
            S_CAPTURE: begin
                cap_en = 1'b1;
                idx_d  = idx_q + 1'b1;
                if (last) begin
                    state_d = S_SEND;
                    idx_d   = '0;
                end
            end
            S_SEND: begin
                if (irst_ready) begin
                    sig_d = {sig_q[DATA_W-2:0], sig_q[DATA_W-1]} ^ cur_word;
                    idx_d = idx_q + 1'b1;
`ifdef IRST_PARITY_EN
                    sig_par_d = sig_par_q ^ (^cur_word);
`endif
                    if (last) begin
                        state_d = S_DONE;
                        idx_d   = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: data and indices are forced to zero outside their phase
    always_comb begin
        reg_read_addr = '0;
        irst_reg_data = '0;
        irst_idx      = '0;
        irst_valid    = 1'b0;
        irst_done     = 1'b0;
        busy          = 1'b0;
        unique case (state_q)
            S_CAPTURE: begin
                reg_read_addr = idx_q;
                busy          = 1'b1;
            end
            S_SEND: begin
                irst_reg_data = cur_word;
                irst_idx      = idx_q;
                irst_valid    = 1'b1;
                busy          = 1'b1;
            end
            S_DONE:  irst_done = 1'b1;
            default: ;
        endcase
    end

    assign irst_sig = sig_q;

`ifdef IRST_PARITY_EN
    assign irst_parity  = ^irst_reg_data;
    assign irst_sig_par = sig_par_q;
`endif

    // State, index, signature and snapshot registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            sig_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sig_q   <= sig_d;
            if (cap_en) begin
                snap_q[idx_q] <= reg_read_data;
            end
        end
    end

`ifdef IRST_PARITY_EN
    // Sticky parity accumulator over accepted words
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_par_q <= 1'b0;
        end else begin
            sig_par_q <= sig_par_d;
        end
    end
`endif

endmodule
